host_ahb_arbiter: RTL and testbench

// Two-master AHB-Lite arbiter and bus multiplexer. It shares the single downstream AHB port (toward
// the system bus / host_ahb_slave side) between M0 (host AHB master, SPI host path) and M1 (secondary

---
 rtl/host_ahb_arbiter_if.sv | 71 +++++++
 rtl/host_ahb_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_host_ahb_arbiter.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/host_ahb_arbiter_if.sv
// Purpose: bundles the two upstream AHB master ports (M0, M1) and the shared downstream AHB port.
// Latency: n/a (signal bundle only).
// Backpressure: n/a; the bus HREADY carried here is the only stall mechanism.
//
// Ports (all signals live in this interface):
//   mN_hbusreq/mN_hlock/mN_htrans/mN_hwrite/mN_hsize/mN_hburst/mN_haddr/mN_hwdata : from master N
//   mN_hgrant/mN_hready/mN_hresp/mN_hrdata                                        : back to master N
//   s_htrans/s_hwrite/s_hsize/s_hburst/s_haddr/s_hwdata                           : to the shared bus
//   s_hrdata/s_hready/s_hresp                                                     : from the shared bus
//   hmaster                                                                       : current address-phase owner
// Modport "master" is the arbiter's view (it masters the shared bus);
// modport "slave" is the surrounding environment's view (masters + bus slave).
interface host_ahb_arbiter_if;
    // M0 request / address / data phase
    logic        m0_hbusreq;
    logic        m0_hlock;
    logic [1:0]  m0_htrans;
    logic        m0_hwrite;
    logic [2:0]  m0_hsize;
    logic [2:0]  m0_hburst;
    logic [31:0] m0_haddr;
    logic [31:0] m0_hwdata;
    logic        m0_hgrant;
    logic        m0_hready;
    logic        m0_hresp;
    logic [31:0] m0_hrdata;

    // M1 request / address / data phase
    logic        m1_hbusreq;
    logic        m1_hlock;
    logic [1:0]  m1_htrans;
    logic        m1_hwrite;
    logic [2:0]  m1_hsize;
    logic [2:0]  m1_hburst;
    logic [31:0] m1_haddr;
    logic [31:0] m1_hwdata;
    logic        m1_hgrant;
    logic        m1_hready;
    logic        m1_hresp;
    logic [31:0] m1_hrdata;

    // shared downstream port
    logic [1:0]  s_htrans;
    logic        s_hwrite;
    logic [2:0]  s_hsize;
    logic [2:0]  s_hburst;
    logic [31:0] s_haddr;
    logic [31:0] s_hwdata;
    logic [31:0] s_hrdata;
    logic        s_hready;
    logic        s_hresp;
    logic        hmaster;

    modport master (
        input  m0_hbusreq, m0_hlock, m0_htrans, m0_hwrite, m0_hsize, m0_hburst, m0_haddr, m0_hwdata,
        output m0_hgrant, m0_hready, m0_hresp, m0_hrdata,
        input  m1_hbusreq, m1_hlock, m1_htrans, m1_hwrite, m1_hsize, m1_hburst, m1_haddr, m1_hwdata,
        output m1_hgrant, m1_hready, m1_hresp, m1_hrdata,
        output s_htrans, s_hwrite, s_hsize, s_hburst, s_haddr, s_hwdata, hmaster,
        input  s_hrdata, s_hready, s_hresp
    );

    modport slave (
        output m0_hbusreq, m0_hlock, m0_htrans, m0_hwrite, m0_hsize, m0_hburst, m0_haddr, m0_hwdata,
        input  m0_hgrant, m0_hready, m0_hresp, m0_hrdata,
        output m1_hbusreq, m1_hlock, m1_htrans, m1_hwrite, m1_hsize, m1_hburst, m1_haddr, m1_hwdata,
        input  m1_hgrant, m1_hready, m1_hresp, m1_hrdata,
        input  s_htrans, s_hwrite, s_hsize, s_hburst, s_haddr, s_hwdata, hmaster,
        output s_hrdata, s_hready, s_hresp
    );
endinterface

// File: rtl/host_ahb_arbiter.sv
// Purpose: two-master AHB-Lite arbiter + bus mux (M0 host/SPI path, M1 debug/DMA) onto one AHB port.
// Latency: grant moves 1 cycle after a handover decision; new owner drives address 1 cycle after grant.
// Backpressure: s_hready=0 freezes every piece of state; s_hready/s_hrdata fan out to both masters.
//
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : host_ahb_arbiter_if.master -- M0/M1 request, address and data phases in,
//           grants/ready/resp/rdata out, shared downstream AHB port, hmaster.
module host_ahb_arbiter #(
    parameter bit DEFAULT_MASTER = 1'b0,  // master parked on the bus when nobody requests
    parameter bit ROUND_ROBIN    = 1'b1   // 1: tie goes to the master that is not the current owner
) (
    input  logic               clk,
    input  logic               reset,
    host_ahb_arbiter_if.master bus
);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;
    localparam logic [2:0] HBURST_INCR   = 3'b001;

    typedef enum logic {
        OWN0 = 1'b0,
        OWN1 = 1'b1
    } owner_e;

    localparam owner_e DEF_OWNER = DEFAULT_MASTER ? OWN1 : OWN0;

    // Remaining-beat count for a fixed-length burst: value loaded on NONSEQ is beats-1.
    function automatic logic [3:0] burst_last(input logic [2:0] hburst);
        case (hburst[2:1])
            2'b01:   burst_last = 4'd3;   // WRAP4 / INCR4
            2'b10:   burst_last = 4'd7;   // WRAP8 / INCR8
            2'b11:   burst_last = 4'd15;  // WRAP16 / INCR16
            default: burst_last = 4'd0;   // SINGLE / INCR
        endcase
    endfunction

    owner_e     owner_q, owner_d;           // address-phase owner (FSM state: OWN0 / OWN1)
    owner_e     grant_q, grant_d;           // master granted the next address phase
    owner_e     data_owner_q, data_owner_d; // master whose transfer is in its data phase
    logic [3:0] beat_cnt_q, beat_cnt_d;
    logic       err_q, err_d;               // owner saw an ERROR and has not gone IDLE yet

    // Owner's view of the address phase
    logic        own_busreq;
    logic        own_lock;
    logic [1:0]  own_htrans;
    logic        own_hwrite;
    logic [2:0]  own_hsize;
    logic [2:0]  own_hburst;
    logic [31:0] own_haddr;

    always_comb begin
        if (owner_q == OWN1) begin
            own_busreq = bus.m1_hbusreq;
            own_lock   = bus.m1_hlock;
            own_htrans = bus.m1_htrans;
            own_hwrite = bus.m1_hwrite;
            own_hsize  = bus.m1_hsize;
            own_hburst = bus.m1_hburst;
            own_haddr  = bus.m1_haddr;
        end else begin
            own_busreq = bus.m0_hbusreq;
            own_lock   = bus.m0_hlock;
            own_htrans = bus.m0_htrans;
            own_hwrite = bus.m0_hwrite;
            own_hsize  = bus.m0_hsize;
            own_hburst = bus.m0_hburst;
            own_haddr  = bus.m0_haddr;
        end
    end

    // Grant already moved but ownership has not: the outgoing owner must not start a transfer.
    logic handing_over;
    assign handing_over = (grant_q != owner_q);

    logic last_beat;   // final beat of a fixed-length burst is on the bus right now
    logic incr_pause;  // undefined-length INCR paused with BUSY
    logic in_error;
    logic handover_ok;

    always_comb begin
        last_beat  = (own_hburst > HBURST_INCR) && (own_htrans == HTRANS_SEQ) && (beat_cnt_q == 4'd1);
        incr_pause = (own_hburst == HBURST_INCR) && (own_htrans == HTRANS_BUSY);
        in_error   = err_q || bus.s_hresp;
        handover_ok = 1'b0;
        if (!own_lock) begin
            // After an ERROR the owner keeps the bus until it returns to IDLE.
            if (in_error) begin
                handover_ok = (own_htrans == HTRANS_IDLE);
            end else begin
                handover_ok = (own_htrans == HTRANS_IDLE) || !own_busreq || last_beat || incr_pause;
            end
        end
    end

    // The current owner doubles as the round-robin pointer: on a tie the other master wins,
    // so priority alternates after every completed tenure.
    owner_e winner;
    always_comb begin
        winner = DEF_OWNER;
        case ({bus.m1_hbusreq, bus.m0_hbusreq})
            2'b01:   winner = OWN0;
            2'b10:   winner = OWN1;
            2'b11:   winner = ROUND_ROBIN ? ((owner_q == OWN0) ? OWN1 : OWN0) : OWN0;
            default: winner = DEF_OWNER;
        endcase
    end

    // Next-state: nothing moves unless the bus accepts the current cycle.
    always_comb begin
        owner_d      = owner_q;
        grant_d      = grant_q;
        data_owner_d = data_owner_q;
        beat_cnt_d   = beat_cnt_q;
        err_d        = err_q;
        if (bus.s_hready) begin
            data_owner_d = owner_q;
            if (handing_over) begin
                owner_d    = grant_q;
                beat_cnt_d = 4'd0;
                err_d      = 1'b0;
            end else begin
                if (handover_ok) begin
                    grant_d = winner;
                end
                if (own_htrans == HTRANS_NONSEQ) begin
                    beat_cnt_d = burst_last(own_hburst);
                end else if ((own_htrans == HTRANS_SEQ) && (beat_cnt_q != 4'd0)) begin
                    beat_cnt_d = beat_cnt_q - 4'd1;
                end
                if (bus.s_hresp) begin
                    err_d = (own_htrans != HTRANS_IDLE);
                end else if (own_htrans == HTRANS_IDLE) begin
                    err_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_q      <= DEF_OWNER;
            grant_q      <= DEF_OWNER;
            data_owner_q <= DEF_OWNER;
            beat_cnt_q   <= 4'd0;
            err_q        <= 1'b0;
        end else begin
            owner_q      <= owner_d;
            grant_q      <= grant_d;
            data_owner_q <= data_owner_d;
            beat_cnt_q   <= beat_cnt_d;
            err_q        <= err_d;
        end
    end

    // Downstream address phase
    always_comb begin
        bus.s_htrans = (reset || handing_over) ? HTRANS_IDLE : own_htrans;
        bus.s_hwrite = own_hwrite;
        bus.s_hsize  = own_hsize;
        bus.s_hburst = own_hburst;
        bus.s_haddr  = own_haddr;
        bus.s_hwdata = (data_owner_q == OWN1) ? bus.m1_hwdata : bus.m0_hwdata;
        bus.hmaster  = (owner_q == OWN1);
    end

    // Responses: ready and read data go to both; an ERROR is shown only to the data-phase owner.
    always_comb begin
        bus.m0_hgrant = (grant_q == OWN0);
        bus.m1_hgrant = (grant_q == OWN1);
        bus.m0_hready = bus.s_hready;
        bus.m1_hready = bus.s_hready;
        bus.m0_hrdata = bus.s_hrdata;
        bus.m1_hrdata = bus.s_hrdata;
        bus.m0_hresp  = bus.s_hresp && (data_owner_q == OWN0);
        bus.m1_hresp  = bus.s_hresp && (data_owner_q == OWN1);
    end

endmodule

// File: tb/tb_host_ahb_arbiter.sv
// Directed bench for host_ahb_arbiter (DEFAULT_MASTER=0, ROUND_ROBIN=1).
// Inputs change 1ns after the rising edge; outputs are checked a further 1ns later.
module tb_host_ahb_arbiter;

    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] NONSEQ = 2'b10;
    localparam logic [1:0] SEQ    = 2'b11;
    localparam logic [2:0] SINGLE = 3'b000;
    localparam logic [2:0] INCR4  = 3'b011;
    localparam logic [2:0] INCR8  = 3'b101;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    host_ahb_arbiter_if bus ();

    host_ahb_arbiter #(.DEFAULT_MASTER(1'b0), .ROUND_ROBIN(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m0(input logic req, input logic lock, input logic [1:0] trans,
                          input logic wr, input logic [2:0] burst, input logic [31:0] addr);
        bus.m0_hbusreq = req;
        bus.m0_hlock   = lock;
        bus.m0_htrans  = trans;
        bus.m0_hwrite  = wr;
        bus.m0_hsize   = 3'b010;
        bus.m0_hburst  = burst;
        bus.m0_haddr   = addr;
    endtask

    task automatic set_m1(input logic req, input logic lock, input logic [1:0] trans,
                          input logic wr, input logic [2:0] burst, input logic [31:0] addr);
        bus.m1_hbusreq = req;
        bus.m1_hlock   = lock;
        bus.m1_htrans  = trans;
        bus.m1_hwrite  = wr;
        bus.m1_hsize   = 3'b010;
        bus.m1_hburst  = burst;
        bus.m1_haddr   = addr;
    endtask

    // Drop all requests and let the bus park on M0.
    task automatic park();
        set_m0(1'b0, 1'b0, IDLE, 1'b0, SINGLE, 32'h0);
        set_m1(1'b0, 1'b0, IDLE, 1'b0, SINGLE, 32'h0);
        bus.s_hready = 1'b1;
        bus.s_hresp  = 1'b0;
        repeat (3) step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_m0(1'b1, 1'b0, NONSEQ, 1'b1, INCR4, 32'h0000_0100);
        set_m1(1'b1, 1'b0, NONSEQ, 1'b1, INCR4, 32'h2000_0000);
        bus.m0_hwdata = 32'h0;
        bus.m1_hwdata = 32'h0;
        bus.s_hready  = 1'b1;
        bus.s_hresp   = 1'b0;
        bus.s_hrdata  = 32'h0;
        repeat (2) step();
        total++; if (bus.s_htrans !== IDLE) begin bad++; $display("FAIL rst_htrans got=%b want=00", bus.s_htrans); end
        total++; if (bus.hmaster !== 1'b0) begin bad++; $display("FAIL rst_hmaster got=%b want=0", bus.hmaster); end
        total++; if (bus.m0_hgrant !== 1'b1) begin bad++; $display("FAIL rst_m0_hgrant got=%b want=1", bus.m0_hgrant); end
        total++; if (bus.m1_hgrant !== 1'b0) begin bad++; $display("FAIL rst_m1_hgrant got=%b want=0", bus.m1_hgrant); end
        reset = 1'b0;
        set_m0(1'b0, 1'b0, IDLE, 1'b0, SINGLE, 32'h0);
        set_m1(1'b0, 1'b0, IDLE, 1'b0, SINGLE, 32'h0);
        repeat (2) step();
        total++; if (bus.hmaster !== 1'b0) begin bad++; $display("FAIL park_hmaster got=%b want=0", bus.hmaster); end
        total++; if (bus.m0_hgrant !== 1'b1) begin bad++; $display("FAIL park_m0_hgrant got=%b want=1", bus.m0_hgrant); end
        total++; if (bus.s_htrans !== IDLE) begin bad++; $display("FAIL park_htrans got=%b want=00", bus.s_htrans); end
    endtask

    task automatic test_m1_single();
        set_m1(1'b1, 1'b0, NONSEQ, 1'b1, SINGLE, 32'h2000_0000);
        #1;
        total++; if (bus.m1_hgrant !== 1'b0) begin bad++; $display("FAIL m1s_grant_early got=%b want=0", bus.m1_hgrant); end
        step();
        total++; if (bus.m1_hgrant !== 1'b1) begin bad++; $display("FAIL m1s_grant got=%b want=1", bus.m1_hgrant); end
        total++; if (bus.hmaster !== 1'b0) begin bad++; $display("FAIL m1s_hmaster_hand got=%b want=0", bus.hmaster); end
        total++; if (bus.s_htrans !== IDLE) begin bad++; $display("FAIL m1s_forced_idle got=%b want=00", bus.s_htrans); end
        step();
        total++; if (bus.hmaster !== 1'b1) begin bad++; $display("FAIL m1s_hmaster got=%b want=1", bus.hmaster); end
        total++; if (bus.s_htrans !== NONSEQ) begin bad++; $display("FAIL m1s_htrans got=%b want=10", bus.s_htrans); end
        total++; if (bus.s_haddr !== 32'h2000_0000) begin bad++; $display("FAIL m1s_haddr got=%h want=20000000", bus.s_haddr); end
        set_m1(1'b0, 1'b0, IDLE, 1'b0, SINGLE, 32'h0);
        bus.m1_hwdata = 32'hCAFE_0001;
        bus.m0_hwdata = 32'h1111_1111;
        step();
        total++; if (bus.s_hwdata !== 32'hCAFE_0001) begin bad++; $display("FAIL m1s_hwdata got=%h want=cafe0001", bus.s_hwdata); end
        step();
        total++; if (bus.m0_hgrant !== 1'b1) begin bad++; $display("FAIL m1s_park_grant got=%b want=1", bus.m0_hgrant); end
        step();
        total++; if (bus.hmaster !== 1'b0) begin bad++; $display("FAIL m1s_park_hmaster got=%b want=0", bus.hmaster); end
        park();
    endtask

    task automatic test_burst_rr();
        set_m1(1'b1, 1'b0, NONSEQ, 1'b0, SINGLE, 32'h3000_0000);
        for (int i = 0; i < 4; i++) begin
            set_m0(1'b1, 1'b0, (i == 0) ? NONSEQ : SEQ, 1'b1, INCR4, 32'h100 + 32'(4 * i));
            #1;
            total++; if (bus.m1_hgrant !== 1'b0) begin bad++; $display("FAIL burst_nogrant beat=%0d got=%b want=0", i, bus.m1_hgrant); end
            total++; if (bus.s_haddr !== 32'h100 + 32'(4 * i)) begin bad++; $display("FAIL burst_haddr beat=%0d got=%h want=%h", i, bus.s_haddr, 32'h100 + 32'(4 * i)); end
            step();
        end
        set_m0(1'b1, 1'b0, NONSEQ, 1'b1, SINGLE, 32'h200);
        #1;
        total++; if (bus.m1_hgrant !== 1'b1) begin bad++; $display("FAIL burst_m1_grant got=%b want=1", bus.m1_hgrant); end
        total++; if (bus.s_htrans !== IDLE) begin bad++; $display("FAIL burst_forced_idle got=%b want=00", bus.s_htrans); end
        step();
        total++; if (bus.hmaster !== 1'b1) begin bad++; $display("FAIL burst_hmaster got=%b want=1", bus.hmaster); end
        total++; if (bus.s_haddr !== 32'h3000_0000) begin bad++; $display("FAIL burst_m1_haddr got=%h want=30000000", bus.s_haddr); end
        step();
        set_m1(1'b1, 1'b0, IDLE, 1'b0, SINGLE, 32'h0);
        #1;
        total++; if (bus.m0_hgrant !== 1'b0) begin bad++; $display("FAIL rr_early got=%b want=0", bus.m0_hgrant); end
        step();
        total++; if (bus.m0_hgrant !== 1'b1) begin bad++; $display("FAIL rr_flip got=%b want=1", bus.m0_hgrant); end
        step();
        total++; if (bus.hmaster !== 1'b0) begin bad++; $display("FAIL rr_hmaster got=%b want=0", bus.hmaster); end
        park();
    endtask

    task automatic test_lock();
        set_m0(1'b1, 1'b1, IDLE, 1'b0, SINGLE, 32'h0);
        set_m1(1'b1, 1'b0, IDLE, 1'b0, SINGLE, 32'h0);
        for (int i = 0; i < 20; i++) begin
            #1;
            total++; if (bus.m1_hgrant !== 1'b0) begin bad++; $display("FAIL lock_hold cyc=%0d got=%b want=0", i, bus.m1_hgrant); end
            step();
        end
        set_m0(1'b1, 1'b0, IDLE, 1'b0, SINGLE, 32'h0);
        step();
        total++; if (bus.m1_hgrant !== 1'b1) begin bad++; $display("FAIL lock_release got=%b want=1", bus.m1_hgrant); end
        park();
    endtask

    task automatic test_stall();
        bus.m1_hwdata = 32'hBBBB_BBBB;
        set_m1(1'b1, 1'b0, IDLE, 1'b0, SINGLE, 32'h0);
        set_m0(1'b1, 1'b0, NONSEQ, 1'b1, INCR8, 32'h400);
        bus.m0_hwdata = 32'h0;
        step();
        set_m0(1'b1, 1'b0, SEQ, 1'b1, INCR8, 32'h404);
        bus.m0_hwdata = 32'hA000_0400;
        step();
        set_m0(1'b1, 1'b0, SEQ, 1'b1, INCR8, 32'h408);
        bus.m0_hwdata = 32'hA000_0404;
        bus.s_hready  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            total++; if (bus.s_hwdata !== 32'hA000_0404) begin bad++; $display("FAIL stall_hwdata cyc=%0d got=%h want=a0000404", i, bus.s_hwdata); end
            total++; if (bus.hmaster !== 1'b0) begin bad++; $display("FAIL stall_hmaster cyc=%0d got=%b want=0", i, bus.hmaster); end
            total++; if (bus.m1_hgrant !== 1'b0) begin bad++; $display("FAIL stall_grant cyc=%0d got=%b want=0", i, bus.m1_hgrant); end
            step();
        end
        bus.s_hready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            set_m0(1'b1, 1'b0, SEQ, 1'b1, INCR8, 32'h408 + 32'(4 * i));
            bus.m0_hwdata = 32'hA000_0404 + 32'(4 * i);
            #1;
            total++; if (bus.m1_hgrant !== 1'b0) begin bad++; $display("FAIL stall_resume beat=%0d got=%b want=0", i, bus.m1_hgrant); end
            step();
        end
        set_m0(1'b1, 1'b0, IDLE, 1'b0, SINGLE, 32'h0);
        #1;
        total++; if (bus.m1_hgrant !== 1'b1) begin bad++; $display("FAIL stall_end_grant got=%b want=1", bus.m1_hgrant); end
        park();
    endtask

    task automatic test_error();
        set_m1(1'b1, 1'b0, IDLE, 1'b0, SINGLE, 32'h0);
        repeat (2) step();
        set_m1(1'b1, 1'b0, NONSEQ, 1'b0, SINGLE, 32'h5000_0000);
        #1;
        total++; if (bus.hmaster !== 1'b1) begin bad++; $display("FAIL err_owner got=%b want=1", bus.hmaster); end
        step();
        set_m0(1'b1, 1'b0, IDLE, 1'b0, SINGLE, 32'h0);
        set_m1(1'b0, 1'b0, NONSEQ, 1'b0, SINGLE, 32'h5000_0000);
        bus.s_hready = 1'b0;
        bus.s_hresp  = 1'b1;
        bus.s_hrdata = 32'hDEAD_BEEF;
        #1;
        total++; if (bus.m1_hresp !== 1'b1) begin bad++; $display("FAIL err_m1_hresp1 got=%b want=1", bus.m1_hresp); end
        total++; if (bus.m0_hresp !== 1'b0) begin bad++; $display("FAIL err_m0_hresp1 got=%b want=0", bus.m0_hresp); end
        total++; if (bus.m0_hrdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL err_m0_hrdata got=%h want=deadbeef", bus.m0_hrdata); end
        total++; if (bus.m1_hrdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL err_m1_hrdata got=%h want=deadbeef", bus.m1_hrdata); end
        total++; if (bus.m0_hready !== 1'b0) begin bad++; $display("FAIL err_m0_hready got=%b want=0", bus.m0_hready); end
        step();
        bus.s_hready = 1'b1;
        #1;
        total++; if (bus.m1_hresp !== 1'b1) begin bad++; $display("FAIL err_m1_hresp2 got=%b want=1", bus.m1_hresp); end
        total++; if (bus.m0_hresp !== 1'b0) begin bad++; $display("FAIL err_m0_hresp2 got=%b want=0", bus.m0_hresp); end
        step();
        bus.s_hresp = 1'b0;
        #1;
        total++; if (bus.m0_hgrant !== 1'b0) begin bad++; $display("FAIL err_hold1 got=%b want=0", bus.m0_hgrant); end
        step();
        set_m1(1'b0, 1'b0, IDLE, 1'b0, SINGLE, 32'h0);
        #1;
        total++; if (bus.m0_hgrant !== 1'b0) begin bad++; $display("FAIL err_hold2 got=%b want=0", bus.m0_hgrant); end
        step();
        total++; if (bus.m0_hgrant !== 1'b1) begin bad++; $display("FAIL err_release got=%b want=1", bus.m0_hgrant); end
        park();
    endtask

    task automatic test_reset_mid();
        set_m1(1'b1, 1'b0, IDLE, 1'b0, SINGLE, 32'h0);
        repeat (2) step();
        set_m1(1'b1, 1'b0, NONSEQ, 1'b1, INCR4, 32'h6000_0000);
        step();
        set_m1(1'b1, 1'b0, SEQ, 1'b1, INCR4, 32'h6000_0004);
        #1;
        total++; if (bus.hmaster !== 1'b1) begin bad++; $display("FAIL rmid_pre_owner got=%b want=1", bus.hmaster); end
        #2;
        reset = 1'b1;
        #1;
        total++; if (bus.hmaster !== 1'b0) begin bad++; $display("FAIL rmid_hmaster got=%b want=0", bus.hmaster); end
        total++; if (bus.m0_hgrant !== 1'b1) begin bad++; $display("FAIL rmid_m0_grant got=%b want=1", bus.m0_hgrant); end
        total++; if (bus.m1_hgrant !== 1'b0) begin bad++; $display("FAIL rmid_m1_grant got=%b want=0", bus.m1_hgrant); end
        total++; if (bus.s_htrans !== IDLE) begin bad++; $display("FAIL rmid_htrans got=%b want=00", bus.s_htrans); end
        step();
        total++; if (bus.s_htrans !== IDLE) begin bad++; $display("FAIL rmid_htrans_hold got=%b want=00", bus.s_htrans); end
        reset = 1'b0;
        park();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_m1_single();
        test_burst_rr();
        test_lock();
        test_stall();
        test_error();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
